// File: rtl/tiny_core_param.sv
// tiny_core_param: parametrised tiny load/store core with a loader-written
// instruction RAM, 16-bit three-operand ISA and valid/ready data ports.
module tiny_core_param #(
    parameter int DATA_WIDTH = 8,
    parameter int IMEM_DEPTH = 16,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int SW = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  prog_we,
    input  logic [AW-1:0]         prog_addr,
    input  logic [15:0]           prog_data,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         pc,
    output logic [2:0]            state,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_EXEC     = 3'd2,
        S_WAIT_IN  = 3'd3,
        S_WAIT_OUT = 3'd4,
        S_HALT     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        F_ADD  = 3'd0,
        F_SUB  = 3'd1,
        F_AND  = 3'd2,
        F_OR   = 3'd3,
        F_XOR  = 3'd4,
        F_SLL  = 3'd5,
        F_SRL  = 3'd6,
        F_SLTU = 3'd7
    } fn_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] rf_q [8];
    logic [15:0]           imem [IMEM_DEPTH];

    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  imem_we;

    logic [3:0]            op;
    logic [2:0]            rd, rs1, rs2;
    fn_e                   fn;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
    logic [DATA_WIDTH-1:0] imm6_sext, imm8_zext;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [SW-1:0]         shamt;
    logic [AW-1:0]         pc_inc, target;

    assign op        = ir_q[15:12];
    assign rd        = ir_q[11:9];
    assign rs1       = ir_q[8:6];
    assign rs2       = ir_q[5:3];
    assign fn        = fn_e'(ir_q[2:0]);
    assign imm6_sext = DATA_WIDTH'($signed(ir_q[5:0]));
    assign imm8_zext = DATA_WIDTH'(ir_q[7:0]);
    assign target    = ir_q[AW-1:0];
    assign pc_inc    = pc_q + AW'(1);

    // x0 is hardwired to zero on the read side
    assign rs1_val = (rs1 == 3'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 3'd0) ? '0 : rf_q[rs2];
    assign shamt   = rs2_val[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (fn)
            F_ADD:   alu_res = rs1_val + rs2_val;
            F_SUB:   alu_res = rs1_val - rs2_val;
            F_AND:   alu_res = rs1_val & rs2_val;
            F_OR:    alu_res = rs1_val | rs2_val;
            F_XOR:   alu_res = rs1_val ^ rs2_val;
            F_SLL:   alu_res = rs1_val << shamt;
            F_SRL:   alu_res = rs1_val >> shamt;
            F_SLTU:  alu_res = DATA_WIDTH'(rs1_val < rs2_val);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rf_we       = 1'b0;
        rf_wdata    = alu_res;
        imem_we     = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                imem_we = prog_we;
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = imem[pc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (op)
                    4'd0: rf_we = 1'b1;
                    4'd1: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs1_val + imm6_sext;
                    end
                    4'd2: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm8_zext;
                    end
                    // I/O advances pc only once the handshake completes
                    4'd3: begin
                        pc_d    = pc_q;
                        state_d = S_WAIT_IN;
                    end
                    4'd4: begin
                        pc_d        = pc_q;
                        out_data_d  = rs1_val;
                        out_valid_d = 1'b1;
                        state_d     = S_WAIT_OUT;
                    end
                    4'd5: if (rs1_val == '0) pc_d = target;
                    4'd6: if (rs1_val != '0) pc_d = target;
                    4'd7: pc_d = target;
                    4'd15: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    rf_we    = 1'b1;
                    rf_wdata = in_data;
                    pc_d     = pc_inc;
                    state_d  = S_FETCH;
                end
            end
            S_WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_inc;
                    state_d     = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else if (rf_we && rd != 3'd0) begin
            rf_q[rd] <= rf_wdata;
        end
    end

    // program RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (imem_we) imem[prog_addr] <= prog_data;
    end

    assign in_ready  = (state_q == S_WAIT_IN);
    assign halted    = (state_q == S_HALT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign pc        = pc_q;
    assign state     = state_q;

endmodule
